// File: rtl/lsu_rmw_pkg.sv
// Shared load/store definitions: funct3 codes, FSM state encoding, and the
// request legality/alignment check that is used when a request is accepted.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_WAIT  = 3'd2,
    ST_WRITE = 3'd3,
    ST_RESP  = 3'd4,
    ST_ERR   = 3'd5
  } state_e;

  // funct3[1:0] encodes log2 of the access size, so alignment only needs the low address bits.
  function automatic logic req_bad(input logic we, input logic [2:0] f3,
                                   input logic [2:0] off, input logic is64);
    logic illegal;
    logic mis;
    illegal = 1'b0;
    mis     = 1'b0;
    case (f3)
      F3_B, F3_H, F3_W: illegal = 1'b0;
      F3_D:             illegal = !is64;
      F3_BU, F3_HU:     illegal = we;
      F3_WU:            illegal = we || !is64;
      default:          illegal = 1'b1;
    endcase
    case (f3[1:0])
      2'b01:   mis = off[0];
      2'b10:   mis = |off[1:0];
      2'b11:   mis = |off;
      default: mis = 1'b0;
    endcase
    return illegal || mis;
  endfunction

endpackage

// File: rtl/lsu_rmw_if.sv
// Core-side request/response and RAM-side signals of the load/store unit.
// The unit owns the slave modport; the core/RAM environment drives the master modport.
interface lsu_rmw_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 16
);
  localparam int WOFF_W = $clog2(DATA_W / 8);

  logic                     req_valid;
  logic                     req_ready;
  logic                     req_we;
  logic [2:0]               req_funct3;
  logic [ADDR_W-1:0]        req_addr;
  logic [DATA_W-1:0]        req_wdata;
  logic                     rsp_valid;
  logic [DATA_W-1:0]        rsp_rdata;
  logic                     rsp_err;
  logic                     mem_en;
  logic                     mem_we;
  logic [ADDR_W-WOFF_W-1:0] mem_addr;
  logic [DATA_W-1:0]        mem_wdata;
  logic [DATA_W-1:0]        mem_rdata;

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
           mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
           mem_en, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/lsu_rmw_lane_align.sv
// Combinational byte-lane handling: extracts and extends a load lane, and
// merges store data into a word. Zero latency, no handshake.
module lsu_lane_align #(
  parameter int DATA_W = 32,
  localparam int WOFF_W = $clog2(DATA_W / 8)
) (
  input  logic [DATA_W-1:0] word_i,
  input  logic [WOFF_W-1:0] off_i,
  input  logic [2:0]        funct3_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] load_o,
  output logic [DATA_W-1:0] merge_o
);

  logic [6:0]        lane_bits;
  logic [DATA_W-1:0] mask;
  logic [DATA_W-1:0] top_bit;
  logic [DATA_W-1:0] shifted;
  logic [DATA_W-1:0] mask_sh;
  logic [DATA_W-1:0] data_sh;
  logic              sgn;

  always_comb begin
    lane_bits = 7'd8 << funct3_i[1:0];
    mask      = '0;
    top_bit   = '0;
    for (int i = 0; i < DATA_W; i++) begin
      mask[i]    = (i < int'(lane_bits));
      top_bit[i] = (i == int'(lane_bits) - 1);
    end
    // Little-endian: lane at byte offset k starts at bit 8k.
    shifted = word_i >> {off_i, 3'b000};
    sgn     = !funct3_i[2] && (|(shifted & top_bit));
    load_o  = (shifted & mask) | (sgn ? ~mask : '0);
    mask_sh = mask << {off_i, 3'b000};
    data_sh = wdata_i << {off_i, 3'b000};
    merge_o = (word_i & ~mask_sh) | (data_sh & mask_sh);
  end

endmodule

// File: rtl/lsu_rmw.sv
// Load/store unit for a RAM without byte enables; sub-word stores become read-modify-write.
// Latency load 3, full store 2, sub-word store 4, error 1; one request at a time, response is an unstalled pulse.
module lsu_rmw
  import lsu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 16
) (
  input logic        clk,
  input logic        rst_n,
  lsu_rmw_if.slave   bus
);

  localparam int         WOFF_W  = $clog2(DATA_W / 8);
  localparam logic       IS64    = (DATA_W == 64);
  localparam logic [2:0] F3_FULL = IS64 ? F3_D : F3_W;

  state_e            state_q, state_d;
  logic              we_q, we_d;
  logic [2:0]        f3_q, f3_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wbuf_q, wbuf_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [DATA_W-1:0] load_val;
  logic [DATA_W-1:0] merge_val;

  // Until WAIT the write buffer holds the raw store data, which feeds the merge.
  lsu_lane_align #(.DATA_W(DATA_W)) u_align (
    .word_i   (bus.mem_rdata),
    .off_i    (addr_q[WOFF_W-1:0]),
    .funct3_i (f3_q),
    .wdata_i  (wbuf_q),
    .load_o   (load_val),
    .merge_o  (merge_val)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      we_q    <= 1'b0;
      f3_q    <= '0;
      addr_q  <= '0;
      wbuf_q  <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      f3_q    <= f3_d;
      addr_q  <= addr_d;
      wbuf_q  <= wbuf_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    f3_d    = f3_q;
    addr_d  = addr_q;
    wbuf_d  = wbuf_q;
    rdata_d = rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.req_valid) begin
          we_d    = bus.req_we;
          f3_d    = bus.req_funct3;
          addr_d  = bus.req_addr;
          wbuf_d  = bus.req_wdata;
          rdata_d = '0;
          if (req_bad(bus.req_we, bus.req_funct3, bus.req_addr[2:0], IS64)) begin
            state_d = ST_ERR;
          end else if (bus.req_we && (bus.req_funct3 == F3_FULL)) begin
            state_d = ST_WRITE;
          end else begin
            state_d = ST_READ;
          end
        end
      end
      ST_READ:  state_d = ST_WAIT;
      ST_WAIT: begin
        if (we_q) begin
          wbuf_d  = merge_val;
          state_d = ST_WRITE;
        end else begin
          rdata_d = load_val;
          state_d = ST_RESP;
        end
      end
      ST_WRITE: state_d = ST_RESP;
      ST_RESP:  state_d = ST_IDLE;
      ST_ERR:   state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // RAM controls come from the registered state only.
  assign bus.req_ready = (state_q == ST_IDLE);
  assign bus.mem_en    = (state_q == ST_READ) || (state_q == ST_WRITE);
  assign bus.mem_we    = (state_q == ST_WRITE);
  assign bus.mem_addr  = addr_q[ADDR_W-1:WOFF_W];
  assign bus.mem_wdata = wbuf_q;
  assign bus.rsp_valid = (state_q == ST_RESP) || (state_q == ST_ERR);
  assign bus.rsp_err   = (state_q == ST_ERR);
  assign bus.rsp_rdata = (state_q == ST_RESP) ? rdata_q : '0;

endmodule

// File: tb/tb_lsu_rmw.sv
// Randomised and directed bench for lsu_rmw (DATA_W=32) with a byte-array
// reference memory and a response scoreboard.
module tb_lsu_rmw;
  import lsu_pkg::*;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 16;
  localparam int NWORDS = 64;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          lat;
    int          rd;
    int          wr;
    int          acc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   rd_cnt = 0;
  int   wr_cnt = 0;

  exp_t        expq[$];
  exp_t        mon_e;
  logic [31:0] ram [0:16383];
  logic [7:0]  refb [0:4*NWORDS-1];

  lsu_rmw_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  lsu_rmw #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous single-port RAM, read data one cycle after the request.
  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
      else            bus.mem_rdata     <= ram[bus.mem_addr];
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic int ref_size(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic logic ref_bad(input logic we, input logic [2:0] f3, input int a);
    if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) return 1'b1;
    if (we && f3 >= 3'd4) return 1'b1;
    return (a % ref_size(f3)) != 0;
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input int a);
    int          n;
    logic [31:0] v;
    n = ref_size(f3);
    v = '0;
    for (int j = 0; j < n; j++) v = v | (32'(refb[a+j]) << (8*j));
    if (!f3[2] && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
    return v;
  endfunction

  task automatic set_word(input int idx, input logic [31:0] val);
    ram[idx] <= val;
    for (int k = 0; k < 4; k++) refb[4*idx+k] = val[8*k +: 8];
  endtask

  task automatic issue(input logic we, input logic [2:0] f3, input int a,
                       input logic [31:0] wd, input bit track);
    int   g;
    exp_t e;
    g = 0;
    @(negedge clk);
    while (!bus.req_ready && g < 40) begin
      @(negedge clk);
      g++;
    end
    if (g >= 40) chk("req_ready_timeout", {31'd0, bus.req_ready}, 32'd1);
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_funct3 = f3;
    bus.req_addr   = 16'(a);
    bus.req_wdata  = wd;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    if (track) begin
      e.acc = cyc;
      e.rdata = '0;
      if (ref_bad(we, f3, a)) begin
        e.err = 1'b1; e.lat = 1; e.rd = 0; e.wr = 0;
      end else if (!we) begin
        e.err = 1'b0; e.lat = 3; e.rd = 1; e.wr = 0;
        e.rdata = ref_load(f3, a);
      end else begin
        e.err = 1'b0;
        if (ref_size(f3) == 4) begin e.lat = 2; e.rd = 0; e.wr = 1; end
        else                   begin e.lat = 4; e.rd = 1; e.wr = 1; end
        for (int j = 0; j < ref_size(f3); j++) refb[a+j] = wd[8*j +: 8];
      end
      expq.push_back(e);
    end
  endtask

  task automatic drain();
    int g;
    g = 0;
    while (expq.size() != 0 && g < 100) begin
      @(negedge clk);
      g++;
    end
    if (g >= 100) chk("drain_timeout", 32'(expq.size()), 32'd0);
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (bus.mem_en === 1'b1 && bus.mem_we === 1'b0) rd_cnt++;
    if (bus.mem_en === 1'b1 && bus.mem_we === 1'b1) wr_cnt++;
    if (bus.rsp_valid === 1'b1) begin
      if (expq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rsp: got rsp_valid=1 expected no response");
      end else begin
        mon_e = expq.pop_front();
        chk("rsp_err", {31'd0, bus.rsp_err}, {31'd0, mon_e.err});
        chk("rsp_rdata", bus.rsp_rdata, mon_e.rdata);
        chk("latency", 32'(cyc - mon_e.acc + 1), 32'(mon_e.lat));
        chk("mem_reads", 32'(rd_cnt), 32'(mon_e.rd));
        chk("mem_writes", 32'(wr_cnt), 32'(mon_e.wr));
      end
      rd_cnt = 0;
      wr_cnt = 0;
    end
  end

  initial begin
    int          a;
    logic [2:0]  f3;
    logic        we;
    logic [31:0] w;

    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_funct3 = '0;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
    for (int i = 0; i < 16384; i++) ram[i] = '0;
    for (int i = 0; i < NWORDS; i++) set_word(i, $urandom);

    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", {31'd0, bus.req_ready}, 32'd1);
    chk("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    chk("rst_rsp_err", {31'd0, bus.rsp_err}, 32'd0);
    chk("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
    chk("rst_mem_en", {31'd0, bus.mem_en}, 32'd0);
    chk("rst_mem_we", {31'd0, bus.mem_we}, 32'd0);
    rst_n = 1'b1;
    rd_cnt = 0;
    wr_cnt = 0;

    // Directed loads, sub-word/full stores and error cases.
    set_word(16, 32'h1122_3344);
    issue(1'b0, F3_B, 'h43, 32'd0, 1'b1);
    issue(1'b0, F3_BU, 'h40, 32'd0, 1'b1);
    drain();
    set_word(16, 32'hFF22_3344);
    issue(1'b0, F3_B, 'h43, 32'd0, 1'b1);
    issue(1'b0, F3_HU, 'h42, 32'd0, 1'b1);
    issue(1'b0, F3_H, 'h42, 32'd0, 1'b1);
    drain();
    set_word(16, 32'h1122_3344);
    issue(1'b1, F3_B, 'h41, 32'h0000_00AB, 1'b1);
    drain();
    chk("sb_merge", ram[16], 32'h1122_AB44);
    set_word(16, 32'h1122_3344);
    issue(1'b1, F3_H, 'h42, 32'h0000_BEEF, 1'b1);
    drain();
    chk("sh_merge", ram[16], 32'hBEEF_3344);
    issue(1'b1, F3_W, 'h44, 32'hCAFE_F00D, 1'b1);
    drain();
    chk("sw_full", ram[17], 32'hCAFE_F00D);
    issue(1'b0, F3_H, 'h41, 32'd0, 1'b1);
    issue(1'b1, F3_W, 'h46, 32'h1234_5678, 1'b1);
    issue(1'b0, F3_D, 'h40, 32'd0, 1'b1);
    issue(1'b0, F3_WU, 'h40, 32'd0, 1'b1);
    issue(1'b0, 3'b111, 'h40, 32'd0, 1'b1);
    issue(1'b1, F3_BU, 'h40, 32'h0000_0077, 1'b1);
    drain();
    chk("err_no_write", ram[17], 32'hCAFE_F00D);

    // Reset while the sub-word store is in WAIT: the write must never be issued.
    set_word(16, 32'h1122_3344);
    drain();
    rd_cnt = 0;
    wr_cnt = 0;
    issue(1'b1, F3_B, 'h42, 32'h0000_005A, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("abort_req_ready", {31'd0, bus.req_ready}, 32'd1);
    chk("abort_mem_en", {31'd0, bus.mem_en}, 32'd0);
    chk("abort_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("abort_ram", ram[16], 32'h1122_3344);
    chk("abort_writes", 32'(wr_cnt), 32'd0);
    chk("abort_reads", 32'(rd_cnt), 32'd1);
    rd_cnt = 0;
    wr_cnt = 0;

    // Random traffic, mostly aligned, all codes and both directions.
    for (int n = 0; n < 250; n++) begin
      we = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      a  = $urandom_range(0, 4*NWORDS-1);
      if ($urandom_range(0, 3) != 0) a = a - (a % ref_size(f3));
      issue(we, f3, a, $urandom, 1'b1);
    end
    drain();

    for (int i = 0; i < NWORDS; i++) begin
      w = {refb[4*i+3], refb[4*i+2], refb[4*i+1], refb[4*i]};
      chk("ram_final", ram[i], w);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
